// File: rtl/exp_table_scheduler.sv
// exp_table_scheduler
// Shares one CalculateExpSigma engine between NREQ requesters. A round-robin
// arbiter grants one requester, its sigma is handed to the engine, and the
// engine's oData/oAddr stream is written into that requester's bank of a
// shared table RAM. A watchdog aborts jobs whose engine never reports done.
// Optional feature: define SIGMA_CACHE_EN to skip recomputation when the
// granted bank already holds a valid table built from the same sigma.
module exp_table_scheduler #(
    parameter int NREQ        = 4,
    parameter int SIGMA_W     = 18,
    parameter int DATA_W      = 18,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 4096,
    localparam int ID_W       = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    iRST_N,
    input  logic [NREQ-1:0]         iReq,
    input  logic [NREQ*SIGMA_W-1:0] iSigma,
    output logic [NREQ-1:0]         oAck,
    output logic                    oErr,
    output logic                    oBusy,
    output logic [NREQ-1:0]         oTblValid,
    output logic                    oEngStart,
    output logic [SIGMA_W-1:0]      oEngSigma,
    input  logic [DATA_W-1:0]       iEngData,
    input  logic [ADDR_W-1:0]       iEngAddr,
    input  logic                    iEngDone,
    output logic                    oWrEn,
    output logic [ID_W+ADDR_W-1:0]  oWrAddr,
    output logic [DATA_W-1:0]       oWrData
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    // Handshake: iReq[k] is a level held until the one-cycle oAck[k] and is
    // dropped on the following edge. The level still present during the ack
    // cycle belongs to the finished job, so it is masked from arbitration.

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [ID_W-1:0]         r_id;
    logic [ID_W-1:0]         r_rr;
    logic [SIGMA_W-1:0]      r_sigma;
    logic [WD_W-1:0]         r_wd;
    logic                    r_ok;
    logic [NREQ-1:0]         r_tbl_valid;
    logic [NREQ-1:0]         r_ack;
    logic                    r_err;
    logic                    r_busy;
    logic                    r_eng_start;
    logic                    r_wr_en;
    logic [ID_W+ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;

    logic [NREQ-1:0]         w_req_m;
    logic [ID_W-1:0]         w_idx;
    logic                    w_found;
    logic [ID_W-1:0]         w_win_id;
    logic [SIGMA_W-1:0]      w_win_sigma;
    logic                    w_hit;
    logic                    w_timeout;

    // Round-robin pick: first pending request at or above the pointer, wrapping.
    always_comb begin
        w_req_m  = iReq & ~r_ack;
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = r_rr + ID_W'(i);
            if (!w_found && w_req_m[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    assign w_win_sigma = iSigma[w_win_id*SIGMA_W +: SIGMA_W];
    assign w_timeout   = (r_wd == WD_LAST);

`ifdef SIGMA_CACHE_EN
    logic [SIGMA_W-1:0] r_bank_sigma [NREQ];

    assign w_hit = r_tbl_valid[w_win_id] && (r_bank_sigma[w_win_id] == w_win_sigma);

    // Remember the sigma behind each successfully built table.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int k = 0; k < NREQ; k++) r_bank_sigma[k] <= '0;
        end else if (r_state == S_DONE && r_ok) begin
            r_bank_sigma[r_id] <= r_sigma;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    // Next-state logic; a late engine done outside RUN is simply not looked at.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nx = w_hit ? S_DONE : S_START;
            S_START: w_state_nx = S_RUN;
            S_RUN:   if (iEngDone || w_timeout) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Registered outputs and job bookkeeping, derived from the current state.
    always_ff @(posedge CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_id        <= '0;
            r_rr        <= '0;
            r_sigma     <= '0;
            r_wd        <= '0;
            r_ok        <= 1'b0;
            r_tbl_valid <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_busy      <= (w_state_nx != S_IDLE);
            r_eng_start <= (r_state == S_START);
            r_wr_en     <= (r_state == S_RUN);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_win_id;
                        r_sigma <= w_win_sigma;
                        r_ok    <= w_hit;
                        if (!w_hit) r_tbl_valid[w_win_id] <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_wr_addr <= {r_id, iEngAddr};
                    r_wr_data <= iEngData;
                    r_wd      <= r_wd + 1'b1;
                    if (iEngDone) r_ok <= 1'b1;
                end
                S_DONE: begin
                    r_ack[r_id] <= 1'b1;
                    r_err       <= !r_ok;
                    if (r_ok) r_tbl_valid[r_id] <= 1'b1;
                    r_rr        <= r_id + 1'b1;
                    r_wd        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign oAck      = r_ack;
    assign oErr      = r_err;
    assign oBusy     = r_busy;
    assign oTblValid = r_tbl_valid;
    assign oEngStart = r_eng_start;
    assign oEngSigma = r_sigma;
    assign oWrEn     = r_wr_en;
    assign oWrAddr   = r_wr_addr;
    assign oWrData   = r_wr_data;

endmodule

// File: tb/tb_exp_table_scheduler.sv
// Testbench for exp_table_scheduler: randomized requester rounds, an engine
// model that streams addr 0..len-1 (or hangs), and a scoreboard monitor.
`timescale 1ns/1ps
module tb_exp_table_scheduler;
  localparam int NREQ = 4;
  localparam int SIGMA_W = 18;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 10;
  localparam int TIMEOUT_CYC = 4096;
  localparam int ID_W = 2;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [SIGMA_W-1:0] sigma;
    logic [13:0]        len;
    logic               hang;
    logic               cached;
    logic [NREQ-1:0]    valid;
  } job_t;
  localparam int JOB_W = $bits(job_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] i_req;
  logic [NREQ*SIGMA_W-1:0] i_sigma;
  logic [NREQ-1:0] o_ack;
  logic o_err, o_busy;
  logic [NREQ-1:0] o_tbl_valid;
  logic o_eng_start;
  logic [SIGMA_W-1:0] o_eng_sigma;
  logic [DATA_W-1:0] i_eng_data;
  logic [ADDR_W-1:0] i_eng_addr;
  logic i_eng_done;
  logic o_wr_en;
  logic [ID_W+ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_table_scheduler dut (
    .CLK(clk), .iRST_N(rst_n), .iReq(i_req), .iSigma(i_sigma),
    .oAck(o_ack), .oErr(o_err), .oBusy(o_busy), .oTblValid(o_tbl_valid),
    .oEngStart(o_eng_start), .oEngSigma(o_eng_sigma),
    .iEngData(i_eng_data), .iEngAddr(i_eng_addr), .iEngDone(i_eng_done),
    .oWrEn(o_wr_en), .oWrAddr(o_wr_addr), .oWrData(o_wr_data)
  );

  // ---------------- checking utilities ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] dfun(input logic [SIGMA_W-1:0] s, input logic [ADDR_W-1:0] a);
    return (s ^ {a, 8'h5a}) + {8'd0, a};
  endfunction

  // ---------------- reference model ----------------
  logic [JOB_W-1:0] exp_q[$];
  logic [14:0]      eng_q[$];
  int               m_rr = 0;
  logic [NREQ-1:0]  m_valid = '0;
  logic [SIGMA_W-1:0] m_bsig [NREQ];
  logic [SIGMA_W-1:0] sig    [NREQ];
  int                 len_a  [NREQ];
  logic [NREQ-1:0]    hang_a = '0;

  // Grant order for a round: repeated round-robin scan of the pending set;
  // a requester that re-requests once after its ack rejoins the pending set.
  task automatic predict_round(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] reuse);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] rl;
    job_t j;
    int w;
    pend = mask;
    rl = reuse;
    while (pend != 0) begin
      w = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (w < 0 && pend[(m_rr + i) % NREQ]) w = (m_rr + i) % NREQ;
      end
      pend[w] = 1'b0;
      if (rl[w]) begin
        rl[w] = 1'b0;
        pend[w] = 1'b1;
      end
      j.id = ID_W'(w);
      j.sigma = sig[w];
      j.len = 14'(len_a[w]);
      j.hang = hang_a[w];
      j.cached = 1'b0;
`ifdef SIGMA_CACHE_EN
      j.cached = m_valid[w] && (m_bsig[w] == sig[w]);
`endif
      if (!j.cached) begin
        m_valid[w] = !hang_a[w];
        if (!hang_a[w]) m_bsig[w] = sig[w];
        eng_q.push_back({hang_a[w], 14'(len_a[w])});
      end
      j.valid = m_valid;
      exp_q.push_back(j);
      m_rr = (w + 1) % NREQ;
    end
  endtask

  // ---------------- engine model ----------------
  logic eng_kill = 1'b0;
  logic stray_done = 1'b0;
  logic eng_active = 1'b0;
  logic eng_hang;
  int   eng_len;
  int   eng_cnt;
  logic [SIGMA_W-1:0] eng_sig;

  always @(posedge clk) begin
    #1;
    if (eng_kill) begin
      eng_active = 1'b0;
    end else if (o_eng_start && !eng_active && eng_q.size() != 0) begin
      {eng_hang, eng_len} = {eng_q[0][14], 18'd0, eng_q[0][13:0]};
      void'(eng_q.pop_front());
      eng_cnt = 0;
      eng_active = 1'b1;
      eng_sig = o_eng_sigma;
    end
    if (eng_active) begin
      i_eng_addr = eng_cnt[ADDR_W-1:0];
      i_eng_data = dfun(eng_sig, eng_cnt[ADDR_W-1:0]);
      // A hanging engine raises a late done one cycle after the watchdog fires.
      i_eng_done = eng_hang ? (eng_cnt == TIMEOUT_CYC) : (eng_cnt == eng_len - 1);
      if (i_eng_done) eng_active = 1'b0;
      eng_cnt++;
    end else begin
      i_eng_addr = ADDR_W'($urandom);
      i_eng_data = DATA_W'($urandom);
      i_eng_done = stray_done;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic job_active = 1'b0;
  job_t cur = '0;
  int   wr_cnt = 0;
  int   exp_wr;
  logic [ADDR_W-1:0] a;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_eng_start) begin
        chk("start_outside_job", 32'(job_active), 0);
        chk("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = job_t'(exp_q.pop_front());
          chk("start_not_cached", 32'(cur.cached), 0);
          chk("eng_sigma", 32'(o_eng_sigma), 32'(cur.sigma));
          chk("busy_in_run", 32'(o_busy), 1);
          job_active = 1'b1;
          wr_cnt = 0;
        end
      end
      if (o_wr_en) begin
        chk("write_in_job", 32'(job_active), 1);
        a = ADDR_W'(wr_cnt % 1024);
        chk("wr_addr", 32'(o_wr_addr), 32'({cur.id, a}));
        chk("wr_data", 32'(o_wr_data), 32'(dfun(cur.sigma, a)));
        chk("sigma_stable", 32'(o_eng_sigma), 32'(cur.sigma));
        wr_cnt++;
      end
      if (o_ack != 0 || o_err) begin
        if (!job_active) begin
          chk("ack_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = job_t'(exp_q.pop_front());
            chk("ack_cached", 32'(cur.cached), 1);
          end
          wr_cnt = 0;
        end
        exp_wr = cur.cached ? 0 : (cur.hang ? TIMEOUT_CYC : int'(cur.len));
        chk("ack_onehot", 32'(o_ack), 32'(1) << cur.id);
        chk("err", 32'(o_err), 32'(cur.hang));
        chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
        chk("tbl_valid", 32'(o_tbl_valid), 32'(cur.valid));
        job_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int raise_cyc;
  int first_ack_cyc;

  task automatic run_round(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] reuse);
    int need, got, n;
    logic [NREQ-1:0] rl, rn;
    for (int k = 0; k < NREQ; k++)
      if (mask[k]) i_sigma[k*SIGMA_W +: SIGMA_W] = sig[k];
    predict_round(mask, reuse);
    i_req = mask;
    raise_cyc = cyc;
    first_ack_cyc = -1;
    need = $countones(mask) + $countones(reuse);
    got = 0;
    n = 0;
    rl = reuse;
    rn = '0;
    while (got < need && n < 30000) begin
      @(posedge clk); #1;
      n++;
      if (rn != 0) begin
        i_req = i_req | rn;
        rn = '0;
      end
      if (o_ack != 0) begin
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
        i_req = i_req & ~o_ack;
        got++;
        rn = o_ack & rl;
        rl = rl & ~o_ack;
      end
      // Idle requesters wiggle their sigma; the running job must not notice.
      for (int k = 0; k < NREQ; k++)
        if (!i_req[k] && !rn[k]) i_sigma[k*SIGMA_W +: SIGMA_W] = SIGMA_W'($urandom);
    end
    chk("round_acks", 32'(got), 32'(need));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [SIGMA_W-1:0] s, input int len, input logic hang);
    sig[k] = s;
    len_a[k] = len;
    hang_a[k] = hang;
  endtask

  // ---------------- main sequence ----------------
  int wr_seen, n, saw;
  logic [NREQ-1:0] mk;

  initial begin
    rst_n = 1'b0;
    i_req = '1;
    i_sigma = '0;
    for (int k = 0; k < NREQ; k++) begin
      m_bsig[k] = '0;
      set_req(k, '0, 1, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_valid", 32'(o_tbl_valid), 0);
    chk("rst_start", 32'(o_eng_start), 0);
    chk("rst_sigma", 32'(o_eng_sigma), 0);
    chk("rst_wren", 32'(o_wr_en), 0);
    chk("rst_wraddr", 32'(o_wr_addr), 0);
    chk("rst_wrdata", 32'(o_wr_data), 0);

    // Round-robin: all four request after reset, requester 0 asks again.
    for (int k = 0; k < NREQ; k++)
      set_req(k, SIGMA_W'($urandom), $urandom_range(1, 40), 1'b0);
    rst_n = 1'b1;
    run_round(4'hF, 4'b0001);

    // Single full-length job on bank 2 with latency check.
    set_req(2, 18'd3408, 1024, 1'b0);
    run_round(4'b0100, 4'b0000);
    chk("single_latency", 32'(first_ack_cyc - raise_cyc), 32'(1024 + 3));

    // Timeout: requester 3 (next in order) hangs, requester 1 proceeds.
    set_req(3, SIGMA_W'($urandom), 16, 1'b1);
    set_req(1, SIGMA_W'($urandom), $urandom_range(1, 64), 1'b0);
    run_round(4'b1010, 4'b0000);
    hang_a = '0;

`ifdef SIGMA_CACHE_EN
    set_req(1, 18'd3408, 8, 1'b0);
    run_round(4'b0010, 4'b0000);
    run_round(4'b0010, 4'b0000);
    chk("cache_latency", 32'(first_ack_cyc - raise_cyc), 2);
    set_req(1, 18'd3409, 8, 1'b0);
    run_round(4'b0010, 4'b0000);
`endif

    // Random rounds.
    repeat (6) begin
      mk = NREQ'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++)
        set_req(k, SIGMA_W'($urandom), $urandom_range(1, 64), 1'b0);
      run_round(mk, mk & NREQ'($urandom));
    end

    // Reset in the middle of a job, at write 500.
    set_req(0, SIGMA_W'($urandom), 1024, 1'b0);
    i_sigma[0 +: SIGMA_W] = sig[0];
    predict_round(4'b0001, 4'b0000);
    i_req = 4'b0001;
    wr_seen = 0;
    n = 0;
    while (wr_seen < 500 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (o_wr_en) wr_seen++;
    end
    chk("mid_run_reached", 32'(wr_seen), 500);
    rst_n = 1'b0;
    eng_kill = 1'b1;
    #1;
    chk("midrst_wren", 32'(o_wr_en), 0);
    chk("midrst_valid", 32'(o_tbl_valid), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_ack", 32'(o_ack), 0);
    exp_q.delete();
    eng_q.delete();
    job_active = 1'b0;
    m_rr = 0;
    m_valid = '0;
    for (int k = 0; k < NREQ; k++) m_bsig[k] = '0;
    i_req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray_done = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_ack != 0 || o_busy || o_wr_en || o_eng_start || o_err) saw = 1;
      stray_done = 1'b0;
    end
    chk("stray_done_ignored", 32'(saw), 0);
    eng_kill = 1'b0;

    // Recovery after reset: pointer restarts at 0.
    for (int k = 0; k < NREQ; k++)
      set_req(k, SIGMA_W'($urandom), $urandom_range(1, 32), 1'b0);
    run_round(4'b1001, 4'b0000);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
